aclk_load_sequencer: RTL and testbench
======================================

# aclk_load_sequencer

Load sequencer for the alarm-clock core. Two requesters (time-set and alarm-set) each present a BCD hh:mm value over a valid/ready handshake. The block validates the value and arbitrates between the requesters. It then drives the clock's H_in1/H_in0/M_in1/M_in0 and LD_time/LD_alarm pins with defined setup, pulse and release timing. It also sequences a clear pulse onto the clock's reset pin.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles digits are stable before the LD pulse (≥1)
- LD_CYCLES, 2, LD pulse width in cycles (≥1)
- RST_CYCLES, 2, width of the clock-clear pulse (≥1)

Ports:
- clk  in  1  sequencer clock (the bench's divided clock)
- reset  in  1  synchronous, active-high reset
- clr_req  in  1  level; request a clock clear
- t_valid / t_ready  in / out  1 / 1  time-set handshake
- t_h1, t_h0, t_m1, t_m0  in  2,4,4,4  time-set BCD digits
- a_valid / a_ready  in / out  1 / 1  alarm-set handshake
- a_h1, a_h0, a_m1, a_m0  in  2,4,4,4  alarm-set BCD digits
- H_in1, H_in0, M_in1, M_in0  out  2,4,4,4  digits to clock core
- LD_time, LD_alarm  out  1  load strobes to clock core
- aclk_reset  out  1  clear pulse to clock core
- busy  out  1  state ≠ IDLE
- done, err  out  1  one-cycle completion / rejection pulses
- src  out  1  source of the current or last transaction (0 = time, 1 = alarm)

## Operation
- States: IDLE, CLEAR, CHECK, SETUP, LOAD, RELEASE.
- IDLE, priority order:
  - clr_req=1: go to CLEAR; both readies are 0 this cycle.
  - Otherwise: t_ready = t_valid && (!a_valid || rr==TIME); a_ready = a_valid && (!t_valid || rr==ALARM).
  - On a handshake: capture the digits and src, go to CHECK.
- Round-robin pointer rr: resets to TIME. After every accepted handshake it points to the other source, even if the value is later rejected.
- CHECK (1 cycle): the value is valid iff h1≤2, h0≤9, (h1==2 → h0≤3), m1≤5, m0≤9.
  - Invalid: err=1 with src set, next state IDLE.
  - Valid: next state SETUP.
- SETUP: lasts SETUP_CYCLES. Captured digits are driven; LD pins are 0.
- LOAD: lasts LD_CYCLES. LD_time (src=0) or LD_alarm (src=1) is 1; digits are held.
- RELEASE (1 cycle): LD pins 0, digits held, done=1. Next state IDLE.
- CLEAR: lasts RST_CYCLES. aclk_reset=1, digit outputs 0. Then IDLE. Neither done nor err is pulsed.
- Digit outputs hold the last loaded value while IDLE, and are 0 after CLEAR or reset.
- One down-counter is shared by SETUP, LOAD and CLEAR. Its width is $clog2(max(param)+1).
- Outputs decode only from registered state; the sole input-to-output paths are t_ready and a_ready.

## Timing
- Reset values:
  - state=IDLE, rr=TIME, src=0.
  - All digit outputs 0; LD_time, LD_alarm, aclk_reset, busy, done, err all 0.
- Reset has priority over every state, including mid-LOAD and mid-CLEAR. LD pins and aclk_reset are 0 in the cycle after the reset edge.
- Latency with defaults, handshake at cycle 0:
  - cycle 1: CHECK
  - cycle 2: SETUP (digits valid from here)
  - cycles 3–4: LOAD
  - cycle 5: RELEASE, done=1
  - cycle 6: ready may assert again
- General formula: LD first high at cycle 2+SETUP_CYCLES; done at cycle 2+SETUP_CYCLES+LD_CYCLES.
- Rejected value: err at cycle 1, IDLE at cycle 2.
- A requester holding valid must keep its digits stable until ready; the block never drops a pending valid.
- clr_req arriving while busy is not latched. It is acted on only if still high when IDLE is reached.

## Structure
- Package aclk_ctrl_pkg:
  - state_e enum; src_e (SRC_TIME=0, SRC_ALARM=1)
  - packed struct hhmm_t {h1[1:0], h0[3:0], m1[3:0], m0[3:0]}
  - function-free constants MAX_H1=2, MAX_H0_AT_2=3, MAX_M1=5
- Sub-module aclk_bcd_check: combinational, hhmm_t in → valid out. It is shared with any future display checker.

## Test plan
- Reset: assert reset 3 cycles with both valids high → all outputs 0, readies 0 during reset; after release t_ready=1, a_ready=0.
- Time load 12:34 (defaults): digits 1/2/3/4 from cycle 2 to cycle 5; LD_time=1 exactly at cycles 3–4; LD_alarm never high; done=1, src=0 at cycle 5.
- Contention: t=08:15 and a=07:00 both valid out of reset → time granted first. Alarm is accepted at cycle 6, LD_alarm=1 at cycles 9–10, and digits read 0/7/0/0.
- Rejection: t=24:00 → err=1, src=0 at cycle 1, no LD pulse, outputs unchanged. Then t=12:60 gets the same response. Then t=23:59 loads normally.
- Clear priority: clr_req and t_valid both high in IDLE → t_ready=0; aclk_reset=1 for 2 cycles with digits 0; the time request is then accepted.
- Reset mid-LOAD: reset at cycle 3 of a 05:30 alarm load → LD_alarm=0 and busy=0 from the next cycle, and no done pulse.

Source files
------------

// File: rtl/aclk_ctrl_pkg.sv
// rtl/aclk_ctrl_pkg.sv - shared types and digit limits for the alarm-clock load sequencer
package aclk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SETUP   = 3'd3,
    ST_LOAD    = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  typedef enum logic {
    SRC_TIME  = 1'b0,
    SRC_ALARM = 1'b1
  } src_e;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  localparam logic [1:0] MAX_H1      = 2'd2;
  localparam logic [3:0] MAX_H0_AT_2 = 4'd3;
  localparam logic [3:0] MAX_M1      = 4'd5;
  localparam logic [3:0] MAX_DIGIT   = 4'd9;

endpackage

// File: rtl/aclk_load_sequencer_if.sv
// rtl/aclk_load_sequencer_if.sv - requester handshakes and clock-core pins of the load sequencer
interface aclk_load_sequencer_if;
  logic       clr_req;
  logic       t_valid;
  logic       t_ready;
  logic [1:0] t_h1;
  logic [3:0] t_h0;
  logic [3:0] t_m1;
  logic [3:0] t_m0;
  logic       a_valid;
  logic       a_ready;
  logic [1:0] a_h1;
  logic [3:0] a_h0;
  logic [3:0] a_m1;
  logic [3:0] a_m0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       aclk_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic       src;

  modport master (
    output clr_req, t_valid, t_h1, t_h0, t_m1, t_m0,
    output a_valid, a_h1, a_h0, a_m1, a_m0,
    input  t_ready, a_ready, H_in1, H_in0, M_in1, M_in0,
    input  LD_time, LD_alarm, aclk_reset, busy, done, err, src
  );

  modport slave (
    input  clr_req, t_valid, t_h1, t_h0, t_m1, t_m0,
    input  a_valid, a_h1, a_h0, a_m1, a_m0,
    output t_ready, a_ready, H_in1, H_in0, M_in1, M_in0,
    output LD_time, LD_alarm, aclk_reset, busy, done, err, src
  );
endinterface

// File: rtl/aclk_bcd_check.sv
// rtl/aclk_bcd_check.sv - combinational BCD hh:mm range check (00:00 .. 23:59)
module aclk_bcd_check
  import aclk_ctrl_pkg::*;
(
  input  hhmm_t val_i,
  output logic  ok_o
);

  always_comb begin
    ok_o = (val_i.h1 <= MAX_H1) &&
           (val_i.h0 <= MAX_DIGIT) &&
           !((val_i.h1 == MAX_H1) && (val_i.h0 > MAX_H0_AT_2)) &&
           (val_i.m1 <= MAX_M1) &&
           (val_i.m0 <= MAX_DIGIT);
  end

endmodule

// File: rtl/aclk_load_sequencer.sv
// rtl/aclk_load_sequencer.sv - arbitrates time/alarm set requests and sequences
// digit setup, LD pulse and clear pulse onto the alarm-clock core
module aclk_load_sequencer
  import aclk_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int LD_CYCLES    = 2,
  parameter int RST_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  aclk_load_sequencer_if.slave  bus
);

  localparam int CNT_MAX_SL = (SETUP_CYCLES > LD_CYCLES) ? SETUP_CYCLES : LD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_SL > RST_CYCLES) ? CNT_MAX_SL : RST_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LAST    = CNT_W'(LD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);

  state_e             state_q;
  src_e               rr_q;
  src_e               src_q;
  hhmm_t              cap_q;
  hhmm_t              dig_q;
  logic               ok_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ld_time_q;
  logic               ld_alarm_q;
  logic               clr_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               t_ready_c;
  logic               a_ready_c;
  hhmm_t              hs_data;
  src_e               hs_src;
  logic               hs_ok;

  // Readies are the only combinational outputs; a clear request masks both.
  always_comb begin
    t_ready_c = 1'b0;
    a_ready_c = 1'b0;
    if (!reset && (state_q == ST_IDLE) && !bus.clr_req) begin
      t_ready_c = bus.t_valid && (!bus.a_valid || (rr_q == SRC_TIME));
      a_ready_c = bus.a_valid && (!bus.t_valid || (rr_q == SRC_ALARM));
    end
    hs_src = a_ready_c ? SRC_ALARM : SRC_TIME;
    if (a_ready_c) begin
      hs_data = '{h1: bus.a_h1, h0: bus.a_h0, m1: bus.a_m1, m0: bus.a_m0};
    end else begin
      hs_data = '{h1: bus.t_h1, h0: bus.t_h0, m1: bus.t_m1, m0: bus.t_m0};
    end
  end

  aclk_bcd_check u_bcd_check (
    .val_i (hs_data),
    .ok_o  (hs_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= SRC_TIME;
      src_q      <= SRC_TIME;
      cap_q      <= '0;
      dig_q      <= '0;
      ok_q       <= 1'b0;
      cnt_q      <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= RST_LAST;
            clr_q   <= 1'b1;
            dig_q   <= '0;
            busy_q  <= 1'b1;
          end else if (t_ready_c || a_ready_c) begin
            // Validity is judged at capture so err lands in the CHECK cycle.
            state_q <= ST_CHECK;
            cap_q   <= hs_data;
            src_q   <= hs_src;
            rr_q    <= (hs_src == SRC_TIME) ? SRC_ALARM : SRC_TIME;
            ok_q    <= hs_ok;
            err_q   <= !hs_ok;
            busy_q  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (ok_q) begin
            state_q <= ST_SETUP;
            cnt_q   <= SETUP_LAST;
            dig_q   <= cap_q;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q    <= ST_LOAD;
            cnt_q      <= LD_LAST;
            ld_time_q  <= (src_q == SRC_TIME);
            ld_alarm_q <= (src_q == SRC_ALARM);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_LOAD: begin
          if (cnt_q == '0) begin
            state_q    <= ST_RELEASE;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_CLEAR: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.t_ready    = t_ready_c;
  assign bus.a_ready    = a_ready_c;
  assign bus.H_in1      = dig_q.h1;
  assign bus.H_in0      = dig_q.h0;
  assign bus.M_in1      = dig_q.m1;
  assign bus.M_in0      = dig_q.m0;
  assign bus.LD_time    = ld_time_q;
  assign bus.LD_alarm   = ld_alarm_q;
  assign bus.aclk_reset = clr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.src        = src_q;

endmodule

// File: tb/tb_aclk_load_sequencer.sv
// tb/tb_aclk_load_sequencer.sv - directed and random checks of aclk_load_sequencer against a timeline model
module tb_aclk_load_sequencer;

  localparam int S = 1;
  localparam int L = 2;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  aclk_load_sequencer_if bus();

  aclk_load_sequencer #(
    .SETUP_CYCLES (S),
    .LD_CYCLES    (L),
    .RST_CYCLES   (R)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] dig_o;
  logic [13:0] tv;
  logic [13:0] av;
  assign dig_o = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
  assign tv    = {bus.t_h1, bus.t_h0, bus.t_m1, bus.t_m0};
  assign av    = {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // A value is loadable iff every digit is decimal and it is a real time of day.
  function automatic bit hhmm_ok(input logic [13:0] v);
    int h1, h0, m1, m0;
    h1 = int'(v[13:12]);
    h0 = int'(v[11:8]);
    m1 = int'(v[7:4]);
    m0 = int'(v[3:0]);
    return (h0 <= 9) && (m0 <= 9) && (m1 <= 9) && (h1 * 10 + h0 < 24) && (m1 * 10 + m0 < 60);
  endfunction

  // Model: mode 0 idle, 1 transaction, 2 clear; m_t counts cycles since the accepting edge.
  int          m_mode = 0;
  int          m_t = 0;
  bit          m_ok = 1'b0;
  bit          m_src = 1'b0;
  bit          m_rr = 1'b0;
  logic [13:0] m_cap = '0;
  logic [13:0] m_dig = '0;
  bit          m_on = 1'b0;
  bit          took_t = 1'b0;
  bit          took_a = 1'b0;

  function automatic bit exp_rdy(input bit me_v, input bit other_v, input bit me);
    return !reset && (m_mode == 0) && !bus.clr_req && me_v && (!other_v || (m_rr == me));
  endfunction

  always @(posedge clk) begin
    took_t = 1'b0;
    took_a = 1'b0;
    if (reset) begin
      m_mode = 0; m_t = 0; m_rr = 1'b0; m_src = 1'b0; m_dig = '0;
    end else if (m_mode == 0) begin
      if (bus.clr_req) begin
        m_mode = 2; m_t = 1; m_dig = '0;
      end else if (exp_rdy(bus.t_valid, bus.a_valid, 1'b0) || exp_rdy(bus.a_valid, bus.t_valid, 1'b1)) begin
        took_a = exp_rdy(bus.a_valid, bus.t_valid, 1'b1);
        took_t = !took_a;
        m_mode = 1; m_t = 1;
        m_src = took_a;
        m_rr  = !took_a;
        m_cap = took_a ? av : tv;
        m_ok  = hhmm_ok(m_cap);
      end
    end else begin
      m_t++;
      if (m_mode == 1 && m_ok && m_t == 2) m_dig = m_cap;
      if (m_mode == 1 && m_t == (m_ok ? 3 + S + L : 2)) m_mode = 0;
      else if (m_mode == 2 && m_t == R + 1) m_mode = 0;
    end
    m_on = 1'b1;
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy",       bus.busy,       m_mode != 0);
      chk("err",        bus.err,        m_mode == 1 && m_t == 1 && !m_ok);
      chk("done",       bus.done,       m_mode == 1 && m_ok && m_t == 2 + S + L);
      chk("ld_time",    bus.LD_time,    m_mode == 1 && m_ok && !m_src && m_t >= 2 + S && m_t < 2 + S + L);
      chk("ld_alarm",   bus.LD_alarm,   m_mode == 1 && m_ok && m_src && m_t >= 2 + S && m_t < 2 + S + L);
      chk("aclk_reset", bus.aclk_reset, m_mode == 2);
      chk("src",        bus.src,        m_src);
      chk("digits",     dig_o,          m_dig);
      chk("t_ready",    bus.t_ready,    exp_rdy(bus.t_valid, bus.a_valid, 1'b0));
      chk("a_ready",    bus.a_ready,    exp_rdy(bus.a_valid, bus.t_valid, 1'b1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit is_a, input logic [13:0] v);
    if (is_a) begin
      bus.a_valid = 1'b1;
      {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} = v;
    end else begin
      bus.t_valid = 1'b1;
      {bus.t_h1, bus.t_h0, bus.t_m1, bus.t_m0} = v;
    end
  endtask

  task automatic xact(input bit is_a, input logic [13:0] v, input bit exp_ok, input logic [13:0] prev);
    drive(is_a, v);
    #1;
    chk("xact_ready", is_a ? bus.a_ready : bus.t_ready, 1);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) begin
        if (is_a) bus.a_valid = 1'b0; else bus.t_valid = 1'b0;
        chk("xact_err", bus.err, !exp_ok);
        chk("xact_src", bus.src, is_a);
      end
      if (c == 2) chk("xact_busy_c2", bus.busy, exp_ok);
      if (c >= 2 && c <= 5) chk("xact_digits", dig_o, exp_ok ? v : prev);
      chk("xact_ld", is_a ? bus.LD_alarm : bus.LD_time, exp_ok && (c == 3 || c == 4));
      chk("xact_ld_other", is_a ? bus.LD_time : bus.LD_alarm, 0);
      chk("xact_done", bus.done, exp_ok && c == 5);
    end
  endtask

  function automatic logic [13:0] rand_hhmm();
    int hh, mm;
    if ($urandom_range(0, 4) != 0) begin
      hh = int'($urandom_range(0, 23));
      mm = int'($urandom_range(0, 59));
      return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    end
    return 14'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    bus.clr_req = 1'b0;
    bus.t_valid = 1'b0;
    bus.a_valid = 1'b0;
    {bus.t_h1, bus.t_h0, bus.t_m1, bus.t_m0} = '0;
    {bus.a_h1, bus.a_h0, bus.a_m1, bus.a_m0} = '0;

    chk("mdl_2400", hhmm_ok(14'h2400), 0);
    chk("mdl_1260", hhmm_ok(14'h1260), 0);
    chk("mdl_2359", hhmm_ok(14'h2359), 1);

    // Reset with both requesters pending, then contention 08:15 vs 07:00.
    reset = 1'b1;
    drive(1'b0, 14'h0815);
    drive(1'b1, 14'h0700);
    repeat (3) begin
      cyc();
      chk("rst_t_ready", bus.t_ready, 0);
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_outs", {bus.busy, bus.done, bus.err, bus.LD_time, bus.LD_alarm, bus.aclk_reset, bus.src}, 0);
      chk("rst_digits", dig_o, 0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_t_ready", bus.t_ready, 1);
    chk("post_rst_a_ready", bus.a_ready, 0);
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 1) bus.t_valid = 1'b0;
      if (c == 7) bus.a_valid = 1'b0;
      if (c == 2) chk("ctn_t_digits", dig_o, 14'h0815);
      if (c == 5) begin
        chk("ctn_t_done", bus.done, 1);
        chk("ctn_t_src", bus.src, 0);
      end
      if (c == 6) begin
        #1;
        chk("ctn_a_ready", bus.a_ready, 1);
      end
      if (c == 9 || c == 10) chk("ctn_ld_alarm", bus.LD_alarm, 1);
      if (c == 11) begin
        chk("ctn_a_done", bus.done, 1);
        chk("ctn_a_digits", dig_o, 14'h0700);
        chk("ctn_a_src", bus.src, 1);
      end
    end
    cyc();

    xact(1'b0, 14'h1234, 1'b1, 14'h0700);
    xact(1'b0, 14'h2400, 1'b0, 14'h1234);
    xact(1'b0, 14'h1260, 1'b0, 14'h1234);
    xact(1'b0, 14'h2359, 1'b1, 14'h1234);

    // Clear takes priority over a pending time request.
    bus.clr_req = 1'b1;
    drive(1'b0, 14'h1111);
    #1;
    chk("clr_t_ready", bus.t_ready, 0);
    cyc();
    bus.clr_req = 1'b0;
    chk("clr_pulse_c1", bus.aclk_reset, 1);
    chk("clr_digits_c1", dig_o, 0);
    cyc();
    chk("clr_pulse_c2", bus.aclk_reset, 1);
    chk("clr_digits_c2", dig_o, 0);
    cyc();
    chk("clr_pulse_end", bus.aclk_reset, 0);
    #1;
    chk("clr_then_t_ready", bus.t_ready, 1);
    cyc();
    bus.t_valid = 1'b0;
    repeat (5) cyc();

    // Reset lands during an alarm LOAD.
    drive(1'b1, 14'h0530);
    #1;
    chk("rml_a_ready", bus.a_ready, 1);
    cyc();
    bus.a_valid = 1'b0;
    cyc();
    cyc();
    chk("rml_ld_before", bus.LD_alarm, 1);
    reset = 1'b1;
    cyc();
    chk("rml_ld_after", bus.LD_alarm, 0);
    chk("rml_busy_after", bus.busy, 0);
    chk("rml_done_after", bus.done, 0);
    reset = 1'b0;
    repeat (3) cyc();

    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (took_t || !bus.t_valid) begin
        if ($urandom_range(0, 2) == 0) drive(1'b0, rand_hhmm());
        else bus.t_valid = 1'b0;
      end
      if (took_a || !bus.a_valid) begin
        if ($urandom_range(0, 2) == 0) drive(1'b1, rand_hhmm());
        else bus.a_valid = 1'b0;
      end
      bus.clr_req = ($urandom_range(0, 40) == 0) || (bus.clr_req && $urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 300) == 0);
    end

    reset = 1'b0;
    bus.clr_req = 1'b0;
    bus.t_valid = 1'b0;
    bus.a_valid = 1'b0;
    repeat (12) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
